// File: rtl/ring_slot_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : ring_arb_pkg                                               |
// | Purpose : Shared types, defaults and helpers for the token-ring      |
// |           slot arbiter and the ring-counter datapath.                |
// | Contents: arb_state_t - arbiter FSM states (SCAN, OWN, REL)          |
// |           rotl1       - one-hot rotate-left by one within a width    |
// |           c_default_n, c_default_max_hold - default sizing           |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package ring_arb_pkg;

  localparam int c_default_n        = 8;
  localparam int c_default_max_hold = 16;

  // Widest ring the rotate helper supports.
  localparam int c_rot_max_w = 64;

  typedef enum logic [1:0] {
    SCAN = 2'd0,
    OWN  = 2'd1,
    REL  = 2'd2
  } arb_state_t;

  // Rotate the low w bits of v left by one, bit w-1 wrapping into bit 0.
  // Bits at and above w are always returned as zero. Requires w >= 2.
  function automatic logic [c_rot_max_w-1:0] rotl1(
    input logic [c_rot_max_w-1:0] v,
    input int                     w
  );
    logic [c_rot_max_w-1:0] one;
    logic [c_rot_max_w-1:0] ones;
    logic [c_rot_max_w-1:0] r;
    one    = '0;
    one[0] = 1'b1;
    ones   = '1;
    r      = v << 1;
    r[0]   = |(v & (one << (w - 1)));
    r      = r & ~(ones << w);
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ring_slot_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface: ring_slot_arbiter_if                                      |
// | Purpose  : Request/grant bundle between requesting engines and the   |
// |            ring slot arbiter.                                        |
// | Signals  : req[N], done[N]            - from requesters              |
// |            grant[N], ring[N], busy,   - from arbiter                 |
// |            timeout                                                   |
// | Modports : master - requester side, slave - arbiter side             |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface ring_slot_arbiter_if
  import ring_arb_pkg::*;
#(
  parameter int N = c_default_n
);

  logic [N-1:0] req;
  logic [N-1:0] done;
  logic [N-1:0] grant;
  logic [N-1:0] ring;
  logic         busy;
  logic         timeout;

  modport master (
    output req,
    output done,
    input  grant,
    input  ring,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output ring,
    output busy,
    output timeout
  );

endinterface
`default_nettype wire

// File: rtl/ring_slot_arbiter_ring_ptr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ring_ptr                                                   |
// | Purpose : One-hot rotating pointer register. Resets to bit 0 and     |
// |           rotates left by one on every enabled clock.                |
// | Ports   : clk    in  1  - rising-edge clock                          |
// |           rst_n  in  1  - asynchronous active-low reset              |
// |           i_en   in  1  - advance the pointer this cycle             |
// |           o_ring out N  - one-hot pointer value                      |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module ring_ptr
  import ring_arb_pkg::*;
#(
  parameter int N = c_default_n
) (
  input  wire          clk,
  input  wire          rst_n,
  input  wire          i_en,
  output logic [N-1:0] o_ring
);

  logic [N-1:0]           r_ring;
  logic [c_rot_max_w-1:0] w_wide;
  logic [c_rot_max_w-1:0] w_rot;

  always_comb begin
    w_wide         = '0;
    w_wide[N-1:0]  = r_ring;
  end

  assign w_rot = rotl1(w_wide, N);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ring <= {{(N-1){1'b0}}, 1'b1};
    end else if (i_en) begin
      r_ring <= w_rot[N-1:0];
    end
  end

  // The helper masks everything above the ring width; nothing may leak out.
  if (N < c_rot_max_w) begin : g_spill_chk
    always_comb begin
      assert (w_rot[c_rot_max_w-1:N] == '0);
    end
  end

  assign o_ring = r_ring;

endmodule
`default_nettype wire

// File: rtl/ring_slot_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ring_slot_arbiter                                          |
// | Purpose : Token-ring scheduler sharing one datapath slot among N     |
// |           requesters. The token rotates while unowned, parks on a    |
// |           requesting position and grants it until done, request      |
// |           drop or hold-budget exhaustion.                            |
// | Ports   : clock in  1 - rising-edge clock                            |
// |           reset in  1 - asynchronous active-low reset                |
// |           bus   slave - req/done in, grant/ring/busy/timeout out     |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module ring_slot_arbiter
  import ring_arb_pkg::*;
#(
  parameter int N        = c_default_n,
  parameter int MAX_HOLD = c_default_max_hold
) (
  input  wire                 clock,
  input  wire                 reset,
  ring_slot_arbiter_if.slave  bus
);

  localparam int                  c_hold_w    = $clog2(MAX_HOLD + 1);
  localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(MAX_HOLD - 1);

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  logic [N-1:0]        r_grant;
  logic [N-1:0]        w_grant_nxt;
  logic                r_busy;
  logic                w_busy_nxt;
  logic                r_timeout;
  logic                w_timeout_nxt;
  logic [c_hold_w-1:0] r_hold_cnt;
  logic [c_hold_w-1:0] w_hold_nxt;
  logic                w_ring_en;
  logic [N-1:0]        w_ring;

  logic w_hit;
  logic w_done_hit;
  logic w_req_drop;
  logic w_budget;
  logic w_release;

  ring_ptr #(
    .N (N)
  ) u_ring_ptr (
    .clk    (clock),
    .rst_n  (reset),
    .i_en   (w_ring_en),
    .o_ring (w_ring)
  );

  // Masking with the owner's grant makes non-owner done/req bits invisible.
  assign w_hit      = |(bus.req & w_ring);
  assign w_done_hit = |(bus.done & r_grant);
  assign w_req_drop = ~|(bus.req & r_grant);
  assign w_budget   = (r_hold_cnt == c_hold_last);
  assign w_release  = w_done_hit | w_req_drop | w_budget;

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_busy_nxt    = r_busy;
    w_timeout_nxt = 1'b0;
    w_hold_nxt    = r_hold_cnt;
    w_ring_en     = 1'b0;
    case (r_state)
      SCAN: begin
        if (w_hit) begin
          w_state_nxt = OWN;
          w_grant_nxt = w_ring;
          w_busy_nxt  = 1'b1;
          w_hold_nxt  = '0;
        end else begin
          w_ring_en = 1'b1;
        end
      end
      OWN: begin
        if (w_release) begin
          w_state_nxt   = REL;
          w_grant_nxt   = '0;
          w_busy_nxt    = 1'b0;
          w_hold_nxt    = '0;
          // A done or request drop landing on the last budget cycle is a
          // normal release, so only a pure budget expiry flags timeout.
          w_timeout_nxt = w_budget & ~w_done_hit & ~w_req_drop;
        end else begin
          w_hold_nxt = r_hold_cnt + 1'b1;
        end
      end
      REL: begin
        // Step past the releasing owner so every other position is scanned
        // before it can be granted again.
        w_ring_en   = 1'b1;
        w_state_nxt = SCAN;
      end
      default: begin
        w_state_nxt = SCAN;
        w_grant_nxt = '0;
        w_busy_nxt  = 1'b0;
        w_hold_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= SCAN;
      r_grant    <= '0;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_busy     <= w_busy_nxt;
      r_timeout  <= w_timeout_nxt;
      r_hold_cnt <= w_hold_nxt;
    end
  end

  assign bus.grant   = r_grant;
  assign bus.ring    = w_ring;
  assign bus.busy    = r_busy;
  assign bus.timeout = r_timeout;

endmodule
`default_nettype wire
